// File: rtl/coef_ram_pkg.sv
// Shared constants for the zigzag coefficient reorder RAM.
// Holds the default geometry and the read latency.
// The read latency depends on the BRAM_OUTREG_EN macro.
package coef_ram_pkg;

    // Default geometry: one 8x8 block of 42-bit coefficients.
    localparam int DATA_W_DEF = 42;
    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 6;

    // Cycles from addrb to doutb.
`ifdef BRAM_OUTREG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

endpackage

// File: rtl/coef_ram_outreg.sv
// Resettable pipeline register of DATA_W bits.
// It is used for the RAM read register and for the optional output register.
// Ports:
//   clk - clock
//   rst - asynchronous active-high clear
//   d   - data in
//   q   - registered data out
module coef_ram_outreg #(
    parameter int DATA_W = 42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/coef_sdp_ram.sv
// Simple dual-port RAM: port A writes and port B does a registered read, on a single clock.
// It is the reorder store for one 8x8 block in the JPEG zigzag stage.
// Ports:
//   clk          - clock
//   rst          - asynchronous active-high clear of the read register(s)
//   wea          - port-A write enable
//   addra        - port-A write address
//   dina         - port-A write data
//   addrb        - port-B read address
//   doutb        - port-B read data
// Read latency:
//   1 cycle by default.
//   2 cycles when BRAM_OUTREG_EN is defined.
// Read-during-write to the same address returns the old data (read-first).
module coef_sdp_ram
    import coef_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    reg [DATA_W-1:0] mem [0:DEPTH-1];

    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_q;

    // Range checks are only needed when the address space exceeds the array.
    generate
        if (DEPTH < (1 << ADDR_W)) begin : g_chk
            assign wr_ok = 32'(addra) < DEPTH;
            assign rd_ok = 32'(addrb) < DEPTH;
        end else begin : g_full
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end
    endgenerate

    // The array has no reset. It matches the block-RAM primitive.
    always_ff @(posedge clk) begin
        if (wea && wr_ok) begin
            mem[addra] <= dina;
        end
    end

    // The read sees the pre-edge contents, which gives read-first behaviour.
    assign rd_word = rd_ok ? mem[addrb] : '0;

    coef_ram_outreg #(
        .DATA_W (DATA_W)
    ) u_rd_reg (
        .clk (clk),
        .rst (rst),
        .d   (rd_word),
        .q   (rd_q)
    );

`ifdef BRAM_OUTREG_EN
    coef_ram_outreg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk (clk),
        .rst (rst),
        .d   (rd_q),
        .q   (doutb)
    );
`else
    assign doutb = rd_q;
`endif

endmodule

// File: tb/tb_coef_sdp_ram.sv
// Directed self-checking bench for coef_sdp_ram.
// It follows the build's READ_LAT, so it covers both BRAM_OUTREG_EN settings.
module tb_coef_sdp_ram;
    import coef_ram_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int AW = ADDR_W_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_v;
    logic [DW-1:0] mem0_v;

    coef_sdp_ram dut (
        .clk   (clk),
        .rst   (rst),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        wea   = 1'b0;
        addra = '0;
        dina  = '0;
        addrb = '0;
        tick();
        tick();
        check("reset_state", doutb, '0);
        rst = 1'b0;

        // Fill the array: mem[a] = a*0x1001.
        for (int a = 0; a < 64; a++) begin
            wea   = 1'b1;
            addra = AW'(a);
            dina  = DW'(a) * DW'(42'h1001);
            tick();
        end
        wea = 1'b0;

        // Stream the reads. Each check lands exactly READ_LAT edges after its address.
        for (int i = 0; i < 64 + READ_LAT - 1; i++) begin
            if (i < 64) addrb = AW'(i);
            tick();
            if (i >= READ_LAT - 1) begin
                exp_v = DW'(i - READ_LAT + 1) * DW'(42'h1001);
                check($sformatf("fill_rd_%0d", i - READ_LAT + 1), doutb, exp_v);
            end
        end

        // Asynchronous reset with nonzero doutb; no clock edge is taken.
        check("pre_reset_nonzero", doutb, 42'h3F03F);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", doutb, '0);
        tick();
        check("reset_hold", doutb, '0);
        rst = 1'b0;
        tick();
        exp_v = (READ_LAT == 1) ? 42'h3F03F : '0;
        check("post_reset_first", doutb, exp_v);
        tick();
        check("post_reset_array_kept", doutb, 42'h3F03F);

        // Read-first on a same-address collision.
        wea   = 1'b1;
        addra = 6'd5;
        dina  = 42'h2A;
        tick();
        addrb = 6'd5;
        dina  = 42'h3FF_FFFF_FFFF;
        tick();
        wea = 1'b0;
        for (int k = 1; k < READ_LAT; k++) tick();
        check("read_first_old", doutb, 42'h2A);
        tick();
        check("read_first_new", doutb, 42'h3FF_FFFF_FFFF);

        // A write with wea=0 must leave the array unchanged.
        wea   = 1'b1;
        addra = 6'd9;
        dina  = 42'h111;
        tick();
        wea  = 1'b0;
        dina = 42'h222;
        tick();
        addrb = 6'd9;
        for (int k = 0; k < READ_LAT; k++) tick();
        check("write_disable", doutb, 42'h111);

        // Hold reads at address 0 while address 63 is written every cycle.
        mem0_v = 42'h0AB_CDEF_1234;
        wea    = 1'b1;
        addra  = 6'd0;
        dina   = mem0_v;
        tick();
        wea   = 1'b0;
        addrb = 6'd0;
        for (int k = 0; k < READ_LAT; k++) tick();
        for (int i = 0; i < 64; i++) begin
            wea   = 1'b1;
            addra = 6'd63;
            dina  = DW'(i * 3 + 1);
            tick();
            check($sformatf("concurrent_%0d", i), doutb, mem0_v);
        end
        wea   = 1'b0;
        addrb = 6'd63;
        for (int k = 0; k < READ_LAT; k++) tick();
        check("concurrent_last_write", doutb, 42'd190);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
